// File: rtl/spram_dma.sv
// spram_dma: block-move engine that masters a single-port RAM with a
// registered read port. Copies src->dst one word at a time (read, then write)
// or fills a destination range with a latched pattern. Addresses wrap modulo
// the RAM size; the word count is one bit wider so a full-RAM move is legal.
module spram_dma #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FILL = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W:0]     cnt_q;
  logic [DATA_W-1:0]   fill_q;
  logic                busy_q;
  logic                done_q;
  logic                cs_q;
  logic                wren_q;
  logic [ADDR_W-1:0]   addr_q;

  // Command sequencer: state, pointers and all RAM-side controls are
  // registered together, so each output reflects the state being entered.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            cnt_q  <= length;
            fill_q <= fill_data;
            if (length == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else if (!mode) begin
              state_q <= RD;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              wren_q  <= 1'b0;
              addr_q  <= src_addr;
            end else begin
              state_q <= FILL;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              wren_q  <= 1'b1;
              addr_q  <= dst_addr;
            end
          end
        end

        RD: begin
          // The word addressed now appears on mem_q during WR.
          state_q <= WR;
          wren_q  <= 1'b1;
          addr_q  <= dst_q;
        end

        WR: begin
          src_q <= src_q + ADDR_ONE;
          dst_q <= dst_q + ADDR_ONE;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cs_q    <= 1'b0;
            wren_q  <= 1'b0;
          end else begin
            state_q <= RD;
            wren_q  <= 1'b0;
            addr_q  <= src_q + ADDR_ONE;
          end
        end

        FILL: begin
          dst_q <= dst_q + ADDR_ONE;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cs_q    <= 1'b0;
            wren_q  <= 1'b0;
          end else begin
            addr_q <= dst_q + ADDR_ONE;
          end
        end

        FIN: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cs_q    <= 1'b0;
          wren_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write data: RAM read data for copies, latched pattern for fills.
  always_comb begin
    mem_data = mode_q ? fill_q : mem_q;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_cs   = cs_q;
  assign mem_wren = wren_q;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_spram_dma.sv
// Testbench for spram_dma: a behavioural registered-output single-port RAM,
// a table of directed commands with hand-computed timing, plus hand-written
// sequences for a mid-command restart attempt and a mid-copy reset.
module tb_spram_dma;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   length;
  logic [DW-1:0] fill_data;
  logic          busy;
  logic          done;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;

  spram_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .busy(busy), .done(done), .mem_cs(mem_cs),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // RAM model: registered read (old data on a same-cycle write), plus a
  // bench-side preload port used only while the engine is idle.
  logic [DW-1:0] ram [NW];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_wdata = '0;
  always @(posedge clock) begin
    if (tb_we) ram[tb_addr] <= tb_wdata;
    else if (mem_cs) begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      mem_q <= ram[mem_addr];
    end
  end

  logic [DW-1:0] gold [NW];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-command observations.
  int       done_cyc, done_cnt, busy_cnt, wr_cnt, cs_cnt, dup_cnt;
  int       wr_cyc  [16];
  logic [AW-1:0] wr_addr [16];
  logic     obs_busy [64];
  logic     obs_wren [64];
  int       hits [NW];

  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] l, input logic [DW-1:0] f,
                         input int extra_k, input int reset_k, input int max_k);
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; wr_cnt = 0; cs_cnt = 0; dup_cnt = 0;
    for (int i = 0; i < NW; i++) hits[i] = 0;
    for (int i = 0; i < 64; i++) begin obs_busy[i] = 1'b0; obs_wren[i] = 1'b0; end
    @(negedge clock);
    mode = m; src_addr = s; dst_addr = d; length = l; fill_data = f; start = 1'b1;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (mem_cs) cs_cnt++;
      if (mem_cs && mem_wren) begin
        if (wr_cnt < 16) begin wr_addr[wr_cnt] = mem_addr; wr_cyc[wr_cnt] = k; end
        wr_cnt++;
        hits[mem_addr]++;
        if (hits[mem_addr] == 2) dup_cnt++;
      end
      if (k < 64) begin obs_busy[k] = busy; obs_wren[k] = mem_wren; end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      start = (k == extra_k);
      if (k == extra_k) begin
        mode = 1'b1; dst_addr = 10'h050; length = 11'd2; fill_data = 8'hEE;
      end
      reset = (k == reset_k);
      if (done_cyc != 0 && k >= done_cyc + 3) break;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic apply_gold(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW:0] l, input logic [DW-1:0] f);
    logic [AW-1:0] sa, da;
    sa = s; da = d;
    for (int i = 0; i < int'(l); i++) begin
      gold[da] = m ? f : gold[sa];
      sa = sa + 1'b1;
      da = da + 1'b1;
    end
  endtask

  function automatic int mem_diff();
    int n;
    n = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== gold[i]) n++;
    return n;
  endfunction

  typedef struct {
    string         name;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill;
    int            exp_done;
    int            exp_busy;
    int            exp_wr;
    int            exp_cs;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"fill_wrap",  1'b1, 10'h000, 10'h3FE, 11'd4,    8'hA5, 5,    4,    4,    4};
    vecs[1] = '{"copy3",      1'b0, 10'h010, 10'h200, 11'd3,    8'h00, 7,    6,    3,    6};
    vecs[2] = '{"copy_len0",  1'b0, 10'h010, 10'h020, 11'd0,    8'h00, 1,    0,    0,    0};
    vecs[3] = '{"fill_len0",  1'b1, 10'h000, 10'h020, 11'd0,    8'h99, 1,    0,    0,    0};
    vecs[4] = '{"copy_ovl",   1'b0, 10'h100, 10'h101, 11'd4,    8'h00, 9,    8,    4,    8};
    vecs[5] = '{"fill_full",  1'b1, 10'h000, 10'h155, 11'd1024, 8'h3C, 1025, 1024, 1024, 1024};

    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_data = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_cs",   32'(mem_cs), 0);
    check("reset_wren", 32'(mem_wren), 0);
    check("reset_addr", 32'(mem_addr), 0);
    reset = 1'b0;

    // Preload RAM with a known pattern through the bench port.
    for (int i = 0; i < NW; i++) begin
      logic [DW-1:0] v;
      v = DW'(i * 7 + 3);
      if (i == 'h10) v = 8'h11;
      if (i == 'h11) v = 8'h22;
      if (i == 'h12) v = 8'h33;
      if (i == 'h100) v = 8'h7E;
      @(negedge clock);
      tb_we = 1'b1; tb_addr = AW'(i); tb_wdata = v;
      gold[i] = v;
    end
    @(negedge clock);
    tb_we = 1'b0;
    @(negedge clock);

    for (int vi = 0; vi < 6; vi++) begin
      run_cmd(vecs[vi].mode, vecs[vi].src, vecs[vi].dst, vecs[vi].len, vecs[vi].fill,
              0, 0, vecs[vi].exp_done + 10);
      check({vecs[vi].name, "_done_cyc"}, 32'(done_cyc), 32'(vecs[vi].exp_done));
      check({vecs[vi].name, "_done_cnt"}, 32'(done_cnt), 1);
      check({vecs[vi].name, "_busy"},     32'(busy_cnt), 32'(vecs[vi].exp_busy));
      check({vecs[vi].name, "_writes"},   32'(wr_cnt),   32'(vecs[vi].exp_wr));
      check({vecs[vi].name, "_cs"},       32'(cs_cnt),   32'(vecs[vi].exp_cs));
      check({vecs[vi].name, "_dups"},     32'(dup_cnt),  0);
      if (vi == 0) begin
        check("fill_wrap_a0", 32'(wr_addr[0]), 32'h3FE);
        check("fill_wrap_a1", 32'(wr_addr[1]), 32'h3FF);
        check("fill_wrap_a2", 32'(wr_addr[2]), 32'h000);
        check("fill_wrap_a3", 32'(wr_addr[3]), 32'h001);
        check("fill_wrap_c0", 32'(wr_cyc[0]), 1);
        check("fill_wrap_c3", 32'(wr_cyc[3]), 4);
        check("fill_wrap_busy4", 32'(obs_busy[4]), 1);
        check("fill_wrap_busy5", 32'(obs_busy[5]), 0);
      end
      if (vi == 1) begin
        check("copy3_wc0", 32'(wr_cyc[0]), 2);
        check("copy3_wc1", 32'(wr_cyc[1]), 4);
        check("copy3_wc2", 32'(wr_cyc[2]), 6);
      end
      apply_gold(vecs[vi].mode, vecs[vi].src, vecs[vi].dst, vecs[vi].len, vecs[vi].fill);
      check({vecs[vi].name, "_ram"}, 32'(mem_diff()), 0);
      if (vi == 1) begin
        check("copy3_r200", 32'(ram[10'h200]), 32'h11);
        check("copy3_r201", 32'(ram[10'h201]), 32'h22);
        check("copy3_r202", 32'(ram[10'h202]), 32'h33);
      end
      if (vi == 4) begin
        for (int a = 'h101; a <= 'h104; a++)
          check("copy_ovl_rep", 32'(ram[a]), 32'h7E);
      end
      if (vi == 5) begin
        check("fill_full_r0",   32'(ram[10'h000]), 32'h3C);
        check("fill_full_r3ff", 32'(ram[10'h3FF]), 32'h3C);
      end
    end

    // Second start in cycle 2 of a 4-word fill must be ignored.
    run_cmd(1'b1, 10'h000, 10'h040, 11'd4, 8'h5A, 2, 0, 40);
    check("restart_done_cyc", 32'(done_cyc), 5);
    check("restart_done_cnt", 32'(done_cnt), 1);
    check("restart_writes",   32'(wr_cnt), 4);
    check("restart_cs",       32'(cs_cnt), 4);
    apply_gold(1'b1, 10'h000, 10'h040, 11'd4, 8'h5A);
    check("restart_ram", 32'(mem_diff()), 0);

    // Reset during cycle 3 of an 8-word copy: one write lands, no done.
    run_cmd(1'b0, 10'h010, 10'h300, 11'd8, 8'h00, 0, 3, 20);
    check("abort_busy_c4", 32'(obs_busy[4]), 0);
    check("abort_wren_c4", 32'(obs_wren[4]), 0);
    check("abort_writes",  32'(wr_cnt), 1);
    check("abort_done",    32'(done_cnt), 0);
    gold[10'h300] = gold[10'h010];
    check("abort_ram", 32'(mem_diff()), 0);

    run_cmd(1'b0, 10'h010, 10'h308, 11'd2, 8'h00, 0, 0, 30);
    check("after_abort_done_cyc", 32'(done_cyc), 5);
    check("after_abort_writes",   32'(wr_cnt), 2);
    apply_gold(1'b0, 10'h010, 10'h308, 11'd2, 8'h00);
    check("after_abort_ram", 32'(mem_diff()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
